// File: rtl/ex_muldiv_if.sv
// Handshake/operand bundle between the ID/EX pipeline register and the EX-stage mul/div unit.
// The pipeline side drives the operation request; the unit returns HI/LO, status and stall.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       alu_code;
    logic [WIDTH-1:0] data_1_in;
    logic [WIDTH-1:0] data_2_in;
    logic             flush;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, alu_code, data_1_in, data_2_in, flush,
        input  hi_out, lo_out, busy, done, stall
    );

    modport slave (
        input  start, alu_code, data_1_in, data_2_in, flush,
        output hi_out, lo_out, busy, done, stall
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32x32 signed/unsigned multiply (shift-add) and divide (restoring) unit with HI/LO.
// One iteration per cycle over 32 cycles, then a sign-fix cycle, then a one-cycle done pulse.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_next;
    logic               valid_code, accept, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               op_div, neg_res, neg_rem, div_zero;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc, mul_step, div_step, product;
    logic [WIDTH-1:0]   opb, hi_q, lo_q, hi_fix, lo_fix;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH+1:0]   rem_diff;
    logic               q_bit;

    assign valid_code = (bus.alu_code[4:2] == 3'b110);
    assign accept     = bus.start && valid_code && !bus.flush;
    assign sgn        = !bus.alu_code[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (bus.flush) state_next = IDLE;
                     else if (cnt == 6'd31) state_next = FIX;
            FIX:     state_next = bus.flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        bus.stall = ((state == IDLE) && accept) || (state == CALC) || (state == FIX);
    end

    // Operand magnitudes for signed ops; unsigned ops pass the raw values through.
    always_comb begin
        a_mag = (sgn && bus.data_1_in[WIDTH-1]) ? -bus.data_1_in : bus.data_1_in;
        b_mag = (sgn && bus.data_2_in[WIDTH-1]) ? -bus.data_2_in : bus.data_2_in;
    end

    // One iteration of each algorithm; acc low half holds the multiplier / dividend bits.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = {1'b0, rem_sh} - {2'b00, opb};
        q_bit    = !rem_diff[WIDTH+1];
        div_step = {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end

    // Sign fix; a zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing.
    always_comb begin
        product = neg_res ? -acc : acc;
        hi_fix  = product[2*WIDTH-1:WIDTH];
        lo_fix  = product[WIDTH-1:0];
        if (op_div) begin
            hi_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_fix = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_div   <= bus.alu_code[1];
                    neg_res  <= sgn && (bus.data_1_in[WIDTH-1] ^ bus.data_2_in[WIDTH-1]);
                    neg_rem  <= sgn && bus.data_1_in[WIDTH-1];
                    div_zero <= (bus.data_2_in == '0);
                    cnt      <= '0;
                    acc      <= {{WIDTH{1'b0}}, (bus.alu_code[1] ? a_mag : b_mag)};
                    opb      <= bus.alu_code[1] ? b_mag : a_mag;
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= op_div ? div_step : mul_step;
                end
                FIX: if (!bus.flush) begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands and ALU code presented by ID/EX and computes signed and unsigned 32x32 multiply and divide. Results go into architectural HI/LO registers. While an operation is in flight it asserts `stall` to freeze IF/ID and ID/EX.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported; HI and LO are each `WIDTH` bits.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: ID/EX presents a mul/div op this cycle. Sampled only in IDLE.
- `alu_code` in 5: operation select.
  - 5'b11000 = MULT (signed)
  - 5'b11001 = MULTU
  - 5'b11010 = DIV (signed)
  - 5'b11011 = DIVU
  - Any other code with `start` = 1 is ignored: no start, no stall.
- `data_1_in` in 32: operand A (multiplicand / dividend).
- `data_2_in` in 32: operand B (multiplier / divisor).
- `flush` in 1: abort any in-flight op (branch/exception squash).
- `hi_out` out 32: MULT = product[63:32]; DIV = remainder.
- `lo_out` out 32: MULT = product[31:0]; DIV = quotient.
- `busy` out 1: state != IDLE (registered).
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `stall` out 1: combinational hold request to the upstream pipeline registers.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If `start` & valid code & !`flush`, then at the edge: latch op, take the magnitudes of A/B (signed ops) or the raw values (unsigned), record the result signs, clear the 6-bit iteration counter, go to CALC.
- **CALC:** one iteration per cycle, 32 cycles (counter 0..31); after iteration 31, go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring; one quotient bit per cycle into a 64-bit remainder/quotient register.
- **FIX:**
  - Apply signs. Signed multiply: negate the 64-bit product if the operand signs differ. Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI/LO and go to DONE.
- **DONE:** `done` = 1 for this single cycle; `start` is ignored; next edge returns to IDLE.
- **`stall`:** asserted when (IDLE & `start` & valid code & !`flush`) or state ∈ {CALC, FIX}. It is low in DONE, so ID/EX advances past the completed op.
- **Divide by zero:** normal latency; HI = dividend (raw operand A), LO = 32'hFFFFFFFF (signed and unsigned).
- **Signed overflow:** 32'h80000000 / 32'hFFFFFFFF gives LO = 32'h80000000, HI = 0, with no trap.
- **`flush`:**
  - In CALC or FIX: next state IDLE; HI/LO unchanged; no `done`.
  - In DONE: no effect (result already committed).
  - In IDLE: suppresses start.
- **Result update:** HI/LO change only on the FIX→DONE edge or reset.

## Timing
- **Reset values:** state IDLE, counter 0, HI = 0, LO = 0, `busy` = 0, `done` = 0, internal accumulators 0. `stall` is therefore 0 unless `start` is asserted.
- **Reset mid-op:** immediate abort to IDLE; HI/LO cleared; no `done`.
- **Latency:**
  - Edge E0 accepts the op.
  - Edges E1..E32 are the iterations; E32 enters FIX.
  - Edge E33 writes HI/LO and enters DONE; `done` is high between E33 and E34.
  - Edge E34 returns to IDLE.
- **Stall window:** `stall` is high for 34 consecutive cycles (the accept cycle plus 33 busy cycles), then low in DONE.
- **Throughput:** a back-to-back op is accepted no earlier than the first IDLE cycle after DONE.
- **Operand latching:** operands are latched at E0; later changes on `data_*_in` have no effect.
- **`flush` with `start`:** `flush` wins.

## Test plan
- **Signed multiply:** MULT, A = 3, B = 32'hFFFFFFFB (-5) -> after E33, HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1, `done` pulse of exactly 1 cycle, `stall` high for exactly 34 cycles.
- **Unsigned multiply:** MULTU, A = B = 32'hFFFFFFFF -> HI = 32'hFFFFFFFE, LO = 32'h00000001. Repeating the same operands with MULT gives HI = 0, LO = 1.
- **Divide:**
  - DIV, A = -7, B = 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF.
  - DIVU, A = 100, B = 7 -> LO = 14, HI = 2.
- **Division corner cases:**
  - DIVU, A = 32'h1234, B = 0 -> LO = 32'hFFFFFFFF, HI = 32'h1234.
  - DIV, A = 32'h80000000, B = 32'hFFFFFFFF -> LO = 32'h80000000, HI = 0.
- **Flush:** `flush` pulse at iteration 10 of a DIV -> IDLE next cycle, HI/LO keep their prior values, no `done`, `stall` drops; a new MULT is then accepted normally.
- **Reset and invalid code:**
  - `rst` asserted asynchronously mid-CALC -> HI = LO = 0, `busy` = 0 without waiting for a clock edge.
  - `start` with `alu_code` = 5'b00010 -> no `stall`, `busy` stays 0.
